exc_commit_ctrl: RTL and testbench

- Sits between the MEM stage and the CP0 register file; sequences exception, interrupt and ERET commits into CP0.
- Arbitrates each cycle between a pending external interrupt and the MEM-stage exception or ERET.
- Holds a commit until instruction and data memory stalls clear, then issues a single-cycle commit strobe to CP0.
- Drives a pipeline flush and a front-end redirect for a programmable number of cycles.

---
 rtl/exc_commit_ctrl_pkg.sv | 29 ++
 rtl/exc_req_arbiter.sv | 47 ++++
 rtl/exc_commit_ctrl.sv | 128 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CP0 definitions: ExcCode values, commit FSM encoding, exception vector.
package exc_commit_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  exc_code;
        logic [31:0] badvaddr;
        logic        is_in_ds;
        logic        is_eret;
    } commit_t;

endpackage

// File: rtl/exc_req_arbiter.sv
// Priority select between interrupt, MEM exception and ERET, plus the data to capture.
// Purely combinational; interrupt > exception > ERET.
module exc_req_arbiter
    import exc_commit_ctrl_pkg::*;
(
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_is_exc,
    input  logic [4:0]  m_exc_code,
    input  logic [31:0] m_badvaddr,
    input  logic        m_is_in_ds,
    input  logic        m_is_eret,
    input  logic        status_exl,
    input  logic        status_ie,
    input  logic        int_pending,
    output logic        req,
    output commit_t     cap
);

    logic int_req;
    logic exc_req;
    logic eret_req;

    always_comb begin
        int_req  = m_valid & int_pending & status_ie & ~status_exl;
        exc_req  = m_valid & m_is_exc & ~m_is_eret;
        eret_req = m_valid & m_is_eret;
        req      = int_req | exc_req | eret_req;

        // EPC for a delay-slot instruction points at the branch (wraps at 0).
        cap.pc       = m_is_in_ds ? (m_pc - 32'd4) : m_pc;
        cap.exc_code = EXC_INT;
        cap.badvaddr = 32'h0;
        cap.is_in_ds = m_is_in_ds;
        cap.is_eret  = 1'b0;

        if (int_req) begin
            cap.exc_code = EXC_INT;
        end else if (exc_req) begin
            cap.exc_code = m_exc_code;
            cap.badvaddr = m_badvaddr;
        end else if (eret_req) begin
            cap.is_eret  = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Sequences exception/interrupt/ERET commits into CP0: capture, wait out memory stalls,
// one-cycle commit strobe, then hold flush for FLUSH_CYCLES cycles in total.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_is_exc,
    input  logic [4:0]  m_exc_code,
    input  logic [31:0] m_badvaddr,
    input  logic        m_is_in_ds,
    input  logic        m_is_eret,
    input  logic        status_exl,
    input  logic        status_ie,
    input  logic        int_pending,
    input  logic [31:0] epc,
    input  logic        iram_stall,
    input  logic        dram_stall,
    output logic        c_valid,
    output logic [31:0] c_pc,
    output logic [4:0]  c_exc_code,
    output logic [31:0] c_badvaddr,
    output logic        c_is_in_ds,
    output logic        c_is_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    commit_t    cap_q, cap_d;
    logic       c_valid_q, c_valid_d;
    logic       flush_q, flush_d;
    logic       redirect_valid_q, redirect_valid_d;

    logic       arb_req;
    commit_t    arb_cap;
    logic       stall;

    exc_req_arbiter u_arb (
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_is_exc    (m_is_exc),
        .m_exc_code  (m_exc_code),
        .m_badvaddr  (m_badvaddr),
        .m_is_in_ds  (m_is_in_ds),
        .m_is_eret   (m_is_eret),
        .status_exl  (status_exl),
        .status_ie   (status_ie),
        .int_pending (int_pending),
        .req         (arb_req),
        .cap         (arb_cap)
    );

    assign stall = iram_stall | dram_stall;

    // Requests are only sampled in IDLE so a captured event can't be overtaken or doubled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_req) begin
                    cap_d   = arb_cap;
                    state_d = stall ? ST_WAIT : ST_COMMIT;
                end
            end
            ST_WAIT: begin
                if (!stall) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                cnt_d   = FLUSH_LOAD;
                state_d = (FLUSH_LOAD != 4'd0) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        c_valid_d        = (state_d == ST_COMMIT);
        redirect_valid_d = (state_d == ST_COMMIT);
        flush_d          = (state_d == ST_COMMIT) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 4'd0;
            cap_q            <= '0;
            c_valid_q        <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cap_q            <= cap_d;
            c_valid_q        <= c_valid_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

    assign c_valid        = c_valid_q;
    assign c_pc           = cap_q.pc;
    assign c_exc_code     = cap_q.exc_code;
    assign c_badvaddr     = cap_q.badvaddr;
    assign c_is_in_ds     = cap_q.is_in_ds;
    assign c_is_eret      = cap_q.is_eret;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    // EPC is taken live so a same-cycle CP0 write to EPC is honoured by ERET.
    assign redirect_pc    = !redirect_valid_q ? 32'h0 : (cap_q.is_eret ? epc : EXC_VECTOR);
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed vector table plus hand sequences for stall, busy-ignore and reset-in-WAIT.
module tb_exc_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_is_exc, m_is_in_ds, m_is_eret;
    logic [31:0] m_pc, m_badvaddr, epc;
    logic [4:0]  m_exc_code;
    logic        status_exl, status_ie, int_pending, iram_stall, dram_stall;
    logic        c_valid, c_is_in_ds, c_is_eret, flush, redirect_valid, busy;
    logic [31:0] c_pc, c_badvaddr, redirect_pc;
    logic [4:0]  c_exc_code;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_pc(m_pc), .m_is_exc(m_is_exc), .m_exc_code(m_exc_code),
        .m_badvaddr(m_badvaddr), .m_is_in_ds(m_is_in_ds), .m_is_eret(m_is_eret),
        .status_exl(status_exl), .status_ie(status_ie), .int_pending(int_pending),
        .epc(epc), .iram_stall(iram_stall), .dram_stall(dram_stall),
        .c_valid(c_valid), .c_pc(c_pc), .c_exc_code(c_exc_code), .c_badvaddr(c_badvaddr),
        .c_is_in_ds(c_is_in_ds), .c_is_eret(c_is_eret), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    typedef struct {
        logic        int_p, ie, exl, valid, exc, eret, ds;
        logic [31:0] pc;
        logic [4:0]  code;
        logic [31:0] bad, epc_v;
        logic        e_cv;
        logic [31:0] e_pc;
        logic [4:0]  e_code;
        logic [31:0] e_bad;
        logic        e_ds, e_eret;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        m_valid = 0; m_is_exc = 0; m_is_eret = 0; m_is_in_ds = 0; int_pending = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " c_valid"}, 32'(c_valid), 0);
        chk({tag, " flush"}, 32'(flush), 0);
        chk({tag, " redirect_valid"}, 32'(redirect_valid), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        reset = 1; clear_req();
        m_pc = 0; m_badvaddr = 0; m_exc_code = 0; epc = 0;
        status_exl = 0; status_ie = 1; iram_stall = 0; dram_stall = 0;

        //            int ie exl val exc eret ds  pc            code   bad           epc           cv  e_pc          e_code e_bad        ds eret rpc
        vecs[0] = '{0, 1, 0, 1, 1, 0, 0, 32'h80001000, 5'h0C, 32'h00001234, 32'h0,        1, 32'h80001000, 5'h0C, 32'h00001234, 0, 0, VEC};
        vecs[1] = '{1, 1, 0, 1, 1, 0, 1, 32'h80002004, 5'h04, 32'h0000DEAD, 32'h0,        1, 32'h80002000, 5'h00, 32'h0,        1, 0, VEC};
        vecs[2] = '{0, 1, 0, 1, 0, 1, 0, 32'h80004000, 5'h00, 32'h0,        32'h80003000, 1, 32'h80004000, 5'h00, 32'h0,        0, 1, 32'h80003000};
        vecs[3] = '{1, 1, 1, 1, 0, 0, 0, 32'h80006000, 5'h00, 32'h0,        32'h0,        0, 32'h0,        5'h00, 32'h0,        0, 0, 32'h0};
        vecs[4] = '{1, 1, 0, 0, 1, 0, 0, 32'h80007000, 5'h0C, 32'h0,        32'h0,        0, 32'h0,        5'h00, 32'h0,        0, 0, 32'h0};
        vecs[5] = '{1, 1, 0, 1, 0, 1, 0, 32'h80005000, 5'h00, 32'h0,        32'h80003000, 1, 32'h80005000, 5'h00, 32'h0,        0, 0, VEC};
        vecs[6] = '{0, 0, 1, 1, 1, 0, 0, 32'h80008000, 5'h0A, 32'h0,        32'h0,        1, 32'h80008000, 5'h0A, 32'h0,        0, 0, VEC};
        vecs[7] = '{0, 1, 0, 1, 1, 0, 1, 32'h00000000, 5'h08, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 5'h08, 32'h0,        1, 0, VEC};
        vecs[8] = '{1, 0, 0, 1, 0, 0, 0, 32'h80009000, 5'h00, 32'h0,        32'h0,        0, 32'h0,        5'h00, 32'h0,        0, 0, 32'h0};
        vecs[9] = '{0, 1, 0, 1, 1, 0, 1, 32'h80010008, 5'h05, 32'hBAD00001, 32'h0,        1, 32'h80010004, 5'h05, 32'hBAD00001, 1, 0, VEC};

        tick(); tick();
        check_idle_outputs("reset");
        chk("reset c_pc", c_pc, 0);
        chk("reset c_exc_code", 32'(c_exc_code), 0);
        chk("reset redirect_pc", redirect_pc, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 10; i++) begin
            int_pending = vecs[i].int_p; status_ie = vecs[i].ie; status_exl = vecs[i].exl;
            m_valid = vecs[i].valid; m_is_exc = vecs[i].exc; m_is_eret = vecs[i].eret;
            m_is_in_ds = vecs[i].ds; m_pc = vecs[i].pc; m_exc_code = vecs[i].code;
            m_badvaddr = vecs[i].bad; epc = vecs[i].epc_v;
            tick();
            clear_req();
            $display("vector %0d", i);
            chk("vec c_valid", 32'(c_valid), 32'(vecs[i].e_cv));
            chk("vec flush", 32'(flush), 32'(vecs[i].e_cv));
            if (vecs[i].e_cv) begin
                chk("vec c_pc", c_pc, vecs[i].e_pc);
                chk("vec c_exc_code", 32'(c_exc_code), 32'(vecs[i].e_code));
                chk("vec c_badvaddr", c_badvaddr, vecs[i].e_bad);
                chk("vec c_is_in_ds", 32'(c_is_in_ds), 32'(vecs[i].e_ds));
                chk("vec c_is_eret", 32'(c_is_eret), 32'(vecs[i].e_eret));
                chk("vec redirect_valid", 32'(redirect_valid), 1);
                chk("vec redirect_pc", redirect_pc, vecs[i].e_rpc);
                chk("vec busy", 32'(busy), 1);
                tick();
                chk("vec flush2 c_valid", 32'(c_valid), 0);
                chk("vec flush2 flush", 32'(flush), 1);
                chk("vec flush2 redirect_valid", 32'(redirect_valid), 0);
                tick();
                check_idle_outputs("vec after");
            end else begin
                chk("vec busy", 32'(busy), 0);
                tick();
                check_idle_outputs("vec none after");
            end
        end

        // ERET with dram_stall held for 3 cycles
        status_exl = 1; status_ie = 1;
        m_valid = 1; m_is_eret = 1; m_pc = 32'h8000A000; epc = 32'h80003000;
        dram_stall = 1;
        tick();
        clear_req();
        for (int k = 0; k < 2; k++) begin
            chk("stall c_valid", 32'(c_valid), 0);
            chk("stall busy", 32'(busy), 1);
            tick();
        end
        chk("stall c_valid", 32'(c_valid), 0);
        chk("stall busy", 32'(busy), 1);
        dram_stall = 0;
        tick();
        chk("stall commit c_valid", 32'(c_valid), 1);
        chk("stall commit eret", 32'(c_is_eret), 1);
        chk("stall commit redirect_pc", redirect_pc, 32'h80003000);
        chk("stall commit busy", 32'(busy), 1);
        tick();
        chk("stall post c_valid", 32'(c_valid), 0);
        chk("stall post flush", 32'(flush), 1);
        chk("stall post busy", 32'(busy), 1);
        tick();
        check_idle_outputs("stall end");

        // Second exception presented during COMMIT/FLUSH is ignored, then taken in IDLE
        status_exl = 0;
        m_valid = 1; m_is_exc = 1; m_exc_code = 5'h0C; m_pc = 32'h8000B000; m_badvaddr = 0;
        tick();
        chk("busy1 c_valid", 32'(c_valid), 1);
        m_exc_code = 5'h0A; m_pc = 32'h8000C000;
        tick();
        chk("busy flush c_valid", 32'(c_valid), 0);
        chk("busy flush c_pc held", c_pc, 32'h8000B000);
        tick();
        chk("busy idle c_valid", 32'(c_valid), 0);
        chk("busy idle busy", 32'(busy), 0);
        tick();
        clear_req();
        chk("busy recommit c_valid", 32'(c_valid), 1);
        chk("busy recommit c_pc", c_pc, 32'h8000C000);
        chk("busy recommit code", 32'(c_exc_code), 32'h0A);
        tick(); tick();
        check_idle_outputs("busy end");

        // Reset while waiting on iram_stall drops the captured exception
        m_valid = 1; m_is_exc = 1; m_exc_code = 5'h04; m_pc = 32'h8000D000; m_badvaddr = 32'h11;
        iram_stall = 1;
        tick();
        clear_req();
        chk("rstwait busy", 32'(busy), 1);
        reset = 1;
        tick();
        check_idle_outputs("rstwait in reset");
        chk("rstwait c_pc", c_pc, 0);
        chk("rstwait c_badvaddr", c_badvaddr, 0);
        reset = 0;
        tick();
        iram_stall = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rstwait no commit", 32'(c_valid), 0);
            chk("rstwait no flush", 32'(flush), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
